adc_sample_scheduler: RTL

- Paces the on-chip modular ADC's Avalon-ST command/response interface at a fixed audio sample rate.
- Each sample period it issues a burst of 2^OVERSAMPLE_LOG2 single-channel conversions, then averages the responses with rounding.
- Emits one 12-bit sample per period to the downstream sample buffer / FFT front end.
- Detects stalled conversions (timeout) and missed sample ticks (overrun), and reports both as sticky flags.

---
 rtl/adc_sample_scheduler.sv | 103 ++++++++++
 1 files changed

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: paces oversampled ADC conversion bursts at a fixed sample rate
// and emits one rounded average per period, with sticky timeout/overrun flags.
module adc_sample_scheduler #(
    parameter int CLK_HZ          = 50000000,
    parameter int SAMPLE_HZ       = 8000,
    parameter int OVERSAMPLE_LOG2 = 2,
    parameter int ADC_CHANNEL     = 1,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_flags,
    output logic        cmd_valid,
    output logic [4:0]  cmd_channel,
    output logic        cmd_sop,
    output logic        cmd_eop,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic [4:0]  rsp_channel,
    input  logic [11:0] rsp_data,
    output logic [11:0] sample_data,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);
    localparam int PERIOD = CLK_HZ / SAMPLE_HZ;
    localparam int N      = OVERSAMPLE_LOG2;
    localparam int TW     = $clog2(PERIOD);
    localparam int OW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW     = 12 + N;
    localparam int RND    = (1 << N) >> 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_q;
    logic [TW-1:0] tick_q;
    logic [N:0]    conv_q;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW:0]   rnd_sum;
    logic [OW-1:0] to_q;
    logic [11:0]   sample_q;
    logic          overrun_q, timeout_q, tick, hit, last, to_fire;

    always_comb begin
        tick    = enable && tick_q == TW'(PERIOD - 1);
        hit     = state_q == WAIT && rsp_valid && rsp_channel == 5'(ADC_CHANNEL);
        acc_d   = acc_q + AW'(rsp_data);
        rnd_sum = {1'b0, acc_d} + (AW+1)'(RND);
        last    = conv_q + 1'b1 == (N+1)'(1 << N);
        // a matching response on the final allowed cycle still counts
        to_fire = state_q == WAIT && !hit && to_q == OW'(TIMEOUT_CYCLES - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            conv_q    <= '0;
            acc_q     <= '0;
            to_q      <= '0;
            sample_q  <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            tick_q    <= (!enable || tick) ? '0 : tick_q + TW'(1);
            overrun_q <= (tick && state_q != IDLE) || (overrun_q && !clear_flags);
            timeout_q <= to_fire || (timeout_q && !clear_flags);
            case (state_q)
                IDLE: if (tick) begin
                    acc_q   <= '0;
                    conv_q  <= '0;
                    state_q <= ISSUE;
                end
                ISSUE: if (cmd_ready) begin
                    to_q    <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (hit) begin
                    acc_q   <= acc_d;
                    conv_q  <= conv_q + 1'b1;
                    state_q <= last ? DONE : ISSUE;
                    if (last) sample_q <= 12'(rnd_sum >> N);
                end else begin
                    to_q <= to_q + OW'(1);
                    if (to_fire) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_valid    = state_q == ISSUE;
    assign cmd_sop      = cmd_valid;
    assign cmd_eop      = cmd_valid;
    assign cmd_channel  = 5'(ADC_CHANNEL);
    assign sample_valid = state_q == DONE;
    assign sample_data  = sample_q;
    assign busy         = state_q != IDLE;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_q;
endmodule
